group_update_sequencer: RTL and testbench
=========================================

# group_update_sequencer

Drives the 3-bit `group_EN` select into the grouped update-order LUT. It steps through the graph-colored p-bit groups in a fixed order, holding each group for a programmable dwell, and repeats the whole order for a requested number of sweeps. It sits between the annealing/factorization controller, which issues a start/done handshake, and the LUT, which expands `group_EN` into the 994-bit `Pbit_EN` mask. The sequencer is the initiator of that select interface.

## Interface
- Parameters:
- `DWELL`, default 2: cycles each group is held with `update_en` high; legal range 1..255.
- `SWEEP_W`, default 16: width of the sweep count and counter.
- Ports:
- `clk` input, 1 bit: single clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: one-cycle request; sampled only in IDLE.
- `num_sweeps` input, `SWEEP_W` bits: sweep count, latched when `start` is accepted.
- `stop` input, 1 bit: abort request.
- `group_EN` output, 3 bits: current group select to the LUT.
- `update_en` output, 1 bit: high while `group_EN` is a valid, active group.
- `busy` output, 1 bit: high in RUN.
- `done` output, 1 bit: one-cycle pulse when all sweeps have completed.
- `sweep_cnt` output, `SWEEP_W` bits: number of completed sweeps in the current or last run.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - `start`=1 with `num_sweeps`≠0: latch `num_sweeps`, clear `sweep_cnt`, set `group_EN`=0, clear the dwell counter, go to RUN.
  - `start`=1 with `num_sweeps`=0: go straight to DONE with no update cycles.
- **RUN**
  - Hold the current group for `DWELL` cycles with `update_en`=1.
  - Then advance the group in the order 0→1→2→3, or 0→1→2→3→4 when the macro is defined.
  - After the last group of a sweep, increment `sweep_cnt`.
    - If the new count equals the latched count, go to DONE.
    - Otherwise set `group_EN`=0 and start the next sweep.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- `stop`=1 in RUN: go to IDLE on the next edge and freeze `sweep_cnt`; `done` is not pulsed. `stop` has no effect in IDLE or DONE.
- `start` while in RUN or DONE: ignored.
- `stop` and the final dwell cycle in the same cycle: `stop` wins; no `done`.
- Outside RUN: `group_EN` is held at 0 and `update_en`=0. The downstream logic gates `Pbit_EN` with `update_en`.
- The dwell counter is 8 bits.
- `sweep_cnt` compares for equality against the latched count and never wraps within a run. The maximum run is 2^`SWEEP_W`−1 sweeps.

## Timing
- Reset values: state=IDLE, `group_EN`=0, `update_en`=0, `busy`=0, `done`=0, `sweep_cnt`=0, dwell counter=0.
- Asserting `rst_n` low mid-run returns all of these immediately. Nothing resumes after reset.
- `start` seen high at edge N: `busy` and `update_en` are high from edge N+1.
- Each group occupies exactly `DWELL` consecutive cycles with no gap between groups or between sweeps.
- A run of S sweeps with G groups keeps `update_en` high for S·G·`DWELL` cycles.
- `done` rises on the edge after the last active cycle. A new `start` is accepted no earlier than the cycle after `done`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `SEQ_CLAMP_GROUP_EN`.
  - Defined: the group order is 0,1,2,3,4 (G=5). Group 4 is the single-bit clamp group and is visited last in every sweep.
  - Undefined: the order is 0,1,2,3 (G=4), and `group_EN` never takes the value 4.
- `group_EN` never takes the values 5–7 in either build.

## Test plan
- Reset, then `start` with `num_sweeps`=1, `DWELL`=2, macro undefined:
  - `group_EN` is 0,0,1,1,2,2,3,3 with `update_en`=1 for those 8 cycles.
  - `done` pulses on cycle 9; `sweep_cnt`=1.
- `num_sweeps`=3 with the macro defined:
  - 30 `update_en` cycles, with group 4 appearing every 5th group slot.
  - `sweep_cnt` reads 1, 2, 3 at the sweep boundaries; one `done` pulse.
- `start` with `num_sweeps`=0: no `update_en` cycles, `done` on the next cycle, `sweep_cnt`=0.
- `stop` during sweep 2, group 1:
  - Next cycle: IDLE, `update_en`=0, `group_EN`=0.
  - `sweep_cnt`=1 and `done` never asserts.
- `rst_n` pulsed low mid-dwell: all outputs go to 0 asynchronously. A following `start` restarts at group 0 with `sweep_cnt`=0.
- `start` re-pulsed during RUN and `stop` raised in the final cycle: the re-pulse is ignored, and the `stop` suppresses `done`.

Source files
------------

// File: rtl/group_update_sequencer_if.sv
// Select/handshake bundle between the sequencer, its controller and the group LUT.
// master = sequencer (drives group select and status), slave = controller/LUT side.
interface group_update_sequencer_if #(
    parameter int SWEEP_W = 16
);
    logic               start;
    logic [SWEEP_W-1:0] num_sweeps;
    logic               stop;
    logic [2:0]         group_EN;
    logic               update_en;
    logic               busy;
    logic               done;
    logic [SWEEP_W-1:0] sweep_cnt;

    modport master (
        input  start,
        input  num_sweeps,
        input  stop,
        output group_EN,
        output update_en,
        output busy,
        output done,
        output sweep_cnt
    );

    modport slave (
        output start,
        output num_sweeps,
        output stop,
        input  group_EN,
        input  update_en,
        input  busy,
        input  done,
        input  sweep_cnt
    );
endinterface

// File: rtl/group_update_sequencer.sv
// Steps group_EN through the colored p-bit groups, DWELL cycles each, for num_sweeps sweeps.
// Outputs valid one cycle after start; stop aborts next edge; macro SEQ_CLAMP_GROUP_EN adds clamp group 4.
module group_update_sequencer #(
    parameter int DWELL   = 2,
    parameter int SWEEP_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    group_update_sequencer_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

`ifdef SEQ_CLAMP_GROUP_EN
    // Clamp group is visited last in every sweep.
    localparam logic [2:0] GRP_LAST = 3'd4;
`else
    localparam logic [2:0] GRP_LAST = 3'd3;
`endif

    localparam logic [SWEEP_W-1:0] SWEEP_ONE = {{(SWEEP_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [2:0]         grp_q, grp_d;
    logic [7:0]         dwell_q, dwell_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic [SWEEP_W-1:0] target_q, target_d;
    logic [SWEEP_W-1:0] sweep_inc;
    logic               last_dwell;
    logic               last_grp;

    assign sweep_inc  = sweep_q + SWEEP_ONE;
    assign last_dwell = (dwell_q == DWELL_LAST);
    assign last_grp   = (grp_q == GRP_LAST);

    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        dwell_d  = dwell_q;
        sweep_d  = sweep_q;
        target_d = target_q;
        case (state_q)
            S_IDLE: begin
                grp_d   = 3'd0;
                dwell_d = 8'd0;
                if (bus.start) begin
                    sweep_d  = '0;
                    target_d = bus.num_sweeps;
                    state_d  = (bus.num_sweeps == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    // Abort wins over any sweep completion in the same cycle.
                    state_d = S_IDLE;
                    grp_d   = 3'd0;
                    dwell_d = 8'd0;
                end else if (!last_dwell) begin
                    dwell_d = dwell_q + 8'd1;
                end else begin
                    dwell_d = 8'd0;
                    if (!last_grp) begin
                        grp_d = grp_q + 3'd1;
                    end else begin
                        grp_d   = 3'd0;
                        sweep_d = sweep_inc;
                        if (sweep_inc == target_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                grp_d   = 3'd0;
                dwell_d = 8'd0;
                state_d = S_IDLE;
            end
            default: begin
                grp_d   = 3'd0;
                dwell_d = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grp_q    <= 3'd0;
            dwell_q  <= 8'd0;
            sweep_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            grp_q    <= grp_d;
            dwell_q  <= dwell_d;
            sweep_q  <= sweep_d;
            target_q <= target_d;
        end
    end

    // Every output is a flop or a decode of the state flop only.
    assign bus.group_EN  = grp_q;
    assign bus.update_en = (state_q == S_RUN);
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.sweep_cnt = sweep_q;

endmodule

// File: tb/tb_group_update_sequencer.sv
// Directed bench for group_update_sequencer: reset, sweeps, zero-sweep, stop, async reset, ignored restart.
module tb_group_update_sequencer;

    localparam int DW = 2;
    localparam int SW = 16;
`ifdef SEQ_CLAMP_GROUP_EN
    localparam int G = 5;
`else
    localparam int G = 4;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   upd_seen;
    int   done_seen;

    always #5 clk = ~clk;

    group_update_sequencer_if #(.SWEEP_W(SW)) bus ();

    group_update_sequencer #(.DWELL(DW), .SWEEP_W(SW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.num_sweeps = '0;
        bus.stop       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grp",  32'(bus.group_EN),  0);
        check("rst_upd",  32'(bus.update_en), 0);
        check("rst_busy", 32'(bus.busy),      0);
        check("rst_done", 32'(bus.done),      0);
        check("rst_cnt",  32'(bus.sweep_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single sweep: groups 0..G-1, each for DW cycles, done on the following cycle
        bus.start = 1'b1; bus.num_sweeps = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < G * DW; i++) begin
            check("t1_upd",  32'(bus.update_en), 1);
            check("t1_busy", 32'(bus.busy),      1);
            check("t1_grp",  32'(bus.group_EN),  32'(i / DW));
            @(negedge clk);
        end
        check("t1_done",   32'(bus.done),      1);
        check("t1_cnt",    32'(bus.sweep_cnt), 1);
        check("t1_updoff", 32'(bus.update_en), 0);
        @(negedge clk);
        check("t1_done_1cyc", 32'(bus.done), 0);
        check("t1_idle",      32'(bus.busy), 0);

        // Three sweeps back to back, no gaps
        bus.start = 1'b1; bus.num_sweeps = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        upd_seen  = 0;
        done_seen = 0;
        for (int s = 0; s < 3; s++) begin
            for (int g = 0; g < G; g++) begin
                for (int d = 0; d < DW; d++) begin
                    if (bus.update_en) upd_seen++;
                    if (bus.done) done_seen++;
                    check("t2_grp", 32'(bus.group_EN),  32'(g));
                    check("t2_cnt", 32'(bus.sweep_cnt), 32'(s));
                    @(negedge clk);
                end
            end
        end
        check("t2_upd_total", 32'(upd_seen), 32'(3 * G * DW));
        check("t2_done", 32'(bus.done),      1);
        check("t2_cnt",  32'(bus.sweep_cnt), 3);
        @(negedge clk);
        check("t2_done_early", 32'(done_seen), 0);
        check("t2_done_1cyc",  32'(bus.done),  0);

        // Zero sweeps: straight to DONE
        bus.start = 1'b1; bus.num_sweeps = 16'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("t3_done", 32'(bus.done),      1);
        check("t3_upd",  32'(bus.update_en), 0);
        check("t3_busy", 32'(bus.busy),      0);
        check("t3_cnt",  32'(bus.sweep_cnt), 0);
        @(negedge clk);
        check("t3_done_1cyc", 32'(bus.done), 0);

        // Stop during sweep 2, group 1
        bus.start = 1'b1; bus.num_sweeps = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (G * DW + DW) @(negedge clk);
        check("t4_pre_grp", 32'(bus.group_EN),  1);
        check("t4_pre_cnt", 32'(bus.sweep_cnt), 1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("t4_upd",  32'(bus.update_en), 0);
        check("t4_grp",  32'(bus.group_EN),  0);
        check("t4_busy", 32'(bus.busy),      0);
        check("t4_cnt",  32'(bus.sweep_cnt), 1);
        done_seen = 0;
        for (int i = 0; i < 2 * G * DW + 4; i++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        check("t4_no_done", 32'(done_seen), 0);
        check("t4_cnt_frozen", 32'(bus.sweep_cnt), 1);

        // Asynchronous reset mid-dwell, then a clean restart
        bus.start = 1'b1; bus.num_sweeps = 16'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (DW + 1) @(negedge clk);
        check("t5_pre_grp", 32'(bus.group_EN), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_grp",  32'(bus.group_EN),  0);
        check("t5_upd",  32'(bus.update_en), 0);
        check("t5_busy", 32'(bus.busy),      0);
        check("t5_done", 32'(bus.done),      0);
        check("t5_cnt",  32'(bus.sweep_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_stay_idle", 32'(bus.busy), 0);
        bus.start = 1'b1; bus.num_sweeps = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t5_re_grp", 32'(bus.group_EN),  0);
        check("t5_re_upd", 32'(bus.update_en), 1);
        check("t5_re_cnt", 32'(bus.sweep_cnt), 0);
        repeat (G * DW + 1) @(negedge clk);
        check("t5_re_idle", 32'(bus.busy), 0);

        // Restart pulse in RUN is ignored; stop in the final active cycle suppresses done
        bus.start = 1'b1; bus.num_sweeps = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < G * DW; i++) begin
            check("t6_grp", 32'(bus.group_EN),  32'(i / DW));
            check("t6_upd", 32'(bus.update_en), 1);
            if (i == 2) begin
                bus.start = 1'b1; bus.num_sweeps = 16'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (i == G * DW - 1) bus.stop = 1'b1;
            @(negedge clk);
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        check("t6_done", 32'(bus.done),      0);
        check("t6_busy", 32'(bus.busy),      0);
        check("t6_upd",  32'(bus.update_en), 0);
        check("t6_cnt",  32'(bus.sweep_cnt), 0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        check("t6_no_done", 32'(done_seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
